commit_trace_fifo: RTL

COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

---
 rtl/commit_trace_fifo.sv | 123 ++++++++++++
 1 files changed

// File: rtl/commit_trace_fifo.sv
// Commit trace capture: arms on trace_en, triggers on a PC match, then logs one
// retirement record per cycle into a FIFO with stop-on-full or drop-and-continue policy.
module commit_trace_fifo #(
  parameter int unsigned DEPTH        = 8,
  parameter bit          STOP_ON_FULL = 1'b1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     trace_en,
  input  logic [31:0]              trig_pc,
  input  logic [31:0]              pc,
  input  logic [31:0]              IDataOut,
  input  logic [4:0]               rd,
  input  logic                     RegWre,
  input  logic [31:0]              wb_data,
  input  logic                     branch,
  input  logic                     zero,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_wbdata,
  output logic [4:0]               out_rd,
  output logic                     out_regwre,
  output logic                     out_taken,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned RecW = 103;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StHalted  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q;
  logic [15:0]     drop_cnt_q;
  logic [RecW-1:0] mem [DEPTH];
  logic [RecW-1:0] rec, head;

  logic trig_hit, eligible, full, pop, push, drop;

  assign rec = {pc, IDataOut, wb_data, rd, RegWre, branch & zero};

  always_comb begin
    trig_hit  = (pc == trig_pc);
    eligible  = trace_en && (((state_q == StArmed) && trig_hit) || (state_q == StCapture));
    full      = (count_q == CW'(DEPTH));
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    push      = eligible && (!full || pop);
    drop      = eligible && full && !pop;
  end

  always_comb begin
    state_d = state_q;
    if (!trace_en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    state_d = StArmed;
        StArmed:   if (trig_hit) state_d = (drop && STOP_ON_FULL) ? StHalted : StCapture;
        StCapture: if (drop && STOP_ON_FULL) state_d = StHalted;
        StHalted:  state_d = StHalted;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= rec;
  end

  assign head = out_valid ? mem[rd_ptr_q] : '0;
  assign {out_pc, out_instr, out_wbdata, out_rd, out_regwre, out_taken} = head;

  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
